// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the CPU instruction-fetch port (I), the CPU data port (D) and the
// program loader (L) share one single-ported memory. Each access moves
// through issue, wait and response phases. The requester that won gets a
// one-cycle ack, or a one-cycle err if its address was misaligned.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request (read only)
//   i_ack/i_err/i_rdata      fetch completion, misalignment pulse, read word
//   d_req/d_we/d_addr/d_wdata  data request (lw/sw)
//   d_ack/d_err/d_rdata      data completion, misalignment pulse, load word
//   l_req/l_we/l_addr/l_wdata  loader request; the low address bits are ignored
//   l_ack/l_rdata            loader completion, read word
//   m_en/m_we/m_addr/m_wdata/m_rdata  memory macro interface
//   busy                     high in every state except IDLE
//
// state | meaning
// IDLE  | arbitrate: L first, then round-robin between I and D
// ISSUE | one-cycle memory strobe using the latched transaction
// WAIT  | count down the read latency, then capture m_rdata
// RESP  | one-cycle ack/err to the owner; requests are ignored here
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_L} owner_e;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // 1: D won the last I/D arbitration, 0: I won it
  logic              rr_last_q, rr_last_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rr_last_q <= 1'b1;
      lat_cnt_q <= 2'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rr_last_q <= rr_last_d;
      lat_cnt_q <= lat_cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_last_d = rr_last_q;
    lat_cnt_d = lat_cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    l_rdata_d = l_rdata_q;
    // D wins when it requests alone, or on a tie when I won last time
    pick_d    = d_req && (!i_req || !rr_last_q);

    case (state_q)
      S_IDLE: begin
        if (l_req) begin
          owner_d = OWN_L;
          we_d    = l_we;
          addr_d  = {l_addr[ADDR_W-1:2], 2'b00};
          wdata_d = l_wdata;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (i_req || d_req) begin
          if (pick_d) begin
            owner_d   = OWN_D;
            we_d      = d_we;
            addr_d    = {d_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = d_wdata;
            err_d     = |d_addr[1:0];
            rr_last_d = 1'b1;
          end else begin
            owner_d   = OWN_I;
            we_d      = 1'b0;
            addr_d    = {i_addr[ADDR_W-1:2], 2'b00};
            err_d     = |i_addr[1:0];
            rr_last_d = 1'b0;
          end
          // a misaligned winner skips the memory entirely
          state_d = err_d ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          case (owner_q)
            OWN_I:   i_rdata_d = m_rdata;
            OWN_D:   d_rdata_d = m_rdata;
            default: l_rdata_d = m_rdata;
          endcase
          state_d = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_ack   = 1'b0;
    i_err   = 1'b0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    l_ack   = 1'b0;
    if (state_q == S_RESP) begin
      case (owner_q)
        OWN_I: begin
          i_ack = !err_q;
          i_err = err_q;
        end
        OWN_D: begin
          d_ack = !err_q;
          d_err = err_q;
        end
        default: l_ack = 1'b1;
      endcase
    end
    m_en    = (state_q == S_ISSUE);
    m_we    = (state_q == S_ISSUE) && we_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    l_rdata = l_rdata_q;
    busy    = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_we, l_req, l_we;
  logic [31:0] i_addr, d_addr, d_wdata, l_addr, l_wdata;

  // dut1: MEM_LAT=1, dut3: MEM_LAT=3; both share the request inputs
  logic        i_ack1, i_err1, d_ack1, d_err1, l_ack1, m_en1, m_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, l_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        i_ack3, i_err3, d_ack3, d_err3, l_ack3, m_en3, m_we3, busy3;
  logic [31:0] i_rdata3, d_rdata3, l_rdata3, m_addr3, m_wdata3, m_rdata3;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_err(i_err1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_err(d_err1), .d_rdata(d_rdata1),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack1), .l_rdata(l_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .busy(busy1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack3), .i_err(i_err3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_err(d_err3), .d_rdata(d_rdata3),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack3), .l_rdata(l_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents after reset: word 0x40 holds 0x2001_0005, others C0DE_<index>
  function automatic logic [31:0] init_word(input int k);
    if (k == 16) return 32'h2001_0005;
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  // memory models; read data outside its valid slot is poisoned
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p1;
  logic [31:0] p3_0, p3_1, p3_2;
  assign m_rdata1 = p1;
  assign m_rdata3 = p3_2;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem1[k] <= init_word(k);
    end else if (m_en1 && m_we1) begin
      mem1[m_addr1[9:2]] <= m_wdata1;
    end
    p1 <= (m_en1 && !m_we1) ? mem1[m_addr1[9:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem3[k] <= init_word(k);
    end else if (m_en3 && m_we3) begin
      mem3[m_addr3[9:2]] <= m_wdata3;
    end
    p3_0 <= (m_en3 && !m_we3) ? mem3[m_addr3[9:2]] : 32'hBAD3_BAD3;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_all();
    i_req = 1'b0; d_req = 1'b0; l_req = 1'b0; d_we = 1'b0; l_we = 1'b0;
  endtask

  // called at a negedge; returns at a negedge with both DUTs idle (cycle 0)
  task automatic do_reset();
    drop_all();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drop_all();
    i_addr = '0; d_addr = '0; d_wdata = '0; l_addr = '0; l_wdata = '0;
    @(negedge clk);
    do_reset();

    // reset state
    check_val("rst_busy", 32'(busy1), 32'd0);
    check_val("rst_men", 32'(m_en1), 32'd0);
    check_val("rst_maddr", m_addr1, 32'h0);
    check_val("rst_irdata", i_rdata1, 32'h0);
    check_val("rst_acks", {29'd0, i_ack1, d_ack1, l_ack1}, 32'd0);

    // single fetch, MEM_LAT=1
    i_req = 1'b1; i_addr = 32'h0000_0040;
    cyc(1);
    check_val("f_men", 32'(m_en1), 32'd1);
    check_val("f_maddr", m_addr1, 32'h40);
    check_val("f_busy1", 32'(busy1), 32'd1);
    cyc(1);
    check_val("f_noack2", 32'(i_ack1), 32'd0);
    check_val("f_men2", 32'(m_en1), 32'd0);
    cyc(1);
    check_val("f_ack", 32'(i_ack1), 32'd1);
    check_val("f_rdata", i_rdata1, 32'h2001_0005);
    check_val("f_busy3", 32'(busy1), 32'd1);
    i_req = 1'b0;
    cyc(1);
    check_val("f_idle", 32'(busy1), 32'd0);

    // I/D tie after reset: I, D, I
    do_reset();
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc(3);
    check_val("t1_iack", 32'(i_ack1), 32'd1);
    check_val("t1_dack", 32'(d_ack1), 32'd0);
    cyc(2);
    check_val("t2_maddr", m_addr1, 32'h100);
    cyc(2);
    check_val("t2_dack", 32'(d_ack1), 32'd1);
    check_val("t2_iack", 32'(i_ack1), 32'd0);
    check_val("t2_drdata", d_rdata1, 32'hC0DE_0040);
    cyc(4);
    check_val("t3_iack", 32'(i_ack1), 32'd1);
    check_val("t3_dack", 32'(d_ack1), 32'd0);
    drop_all();
    cyc(1);

    // store then load back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    cyc(1);
    check_val("st_men", 32'(m_en1), 32'd1);
    check_val("st_mwe", 32'(m_we1), 32'd1);
    check_val("st_maddr", m_addr1, 32'h200);
    check_val("st_mwdata", m_wdata1, 32'hDEAD_BEEF);
    cyc(1);
    check_val("st_ack", 32'(d_ack1), 32'd1);
    drop_all();
    cyc(1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    cyc(1);
    check_val("ld_mwe", 32'(m_we1), 32'd0);
    cyc(2);
    check_val("ld_ack", 32'(d_ack1), 32'd1);
    check_val("ld_rdata", d_rdata1, 32'hDEAD_BEEF);
    drop_all();
    cyc(1);

    // loader arrives mid-fetch, served before a pending data read
    i_req = 1'b1; i_addr = 32'h40;
    cyc(1);
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0000_0013;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc(2);
    check_val("ld_iack", 32'(i_ack1), 32'd1);
    check_val("ld_lack_early", 32'(l_ack1), 32'd0);
    i_req = 1'b0;
    cyc(2);
    check_val("l_maddr", m_addr1, 32'h10);
    cyc(2);
    check_val("l_ack", 32'(l_ack1), 32'd1);
    check_val("l_rdata", l_rdata1, 32'hC0DE_0004);
    check_val("l_dack", 32'(d_ack1), 32'd0);
    l_req = 1'b0;
    cyc(4);
    check_val("l_then_dack", 32'(d_ack1), 32'd1);
    check_val("l_then_drdata", d_rdata1, 32'hC0DE_0040);
    drop_all();
    cyc(1);

    // misaligned data and fetch requests
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0102;
    cyc(1);
    check_val("mis_derr", 32'(d_err1), 32'd1);
    check_val("mis_dack", 32'(d_ack1), 32'd0);
    check_val("mis_men", 32'(m_en1), 32'd0);
    check_val("mis_busy", 32'(busy1), 32'd1);
    drop_all();
    cyc(1);
    check_val("mis_men2", 32'(m_en1), 32'd0);
    check_val("mis_derr2", 32'(d_err1), 32'd0);
    check_val("mis_dack2", 32'(d_ack1), 32'd0);
    i_req = 1'b1; i_addr = 32'h0000_0041;
    cyc(1);
    check_val("mis_ierr", 32'(i_err1), 32'd1);
    check_val("mis_iack", 32'(i_ack1), 32'd0);
    drop_all();
    cyc(1);

    // MEM_LAT=3: reset during WAIT discards the read
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc(1);
    check_val("l3_men", 32'(m_en3), 32'd1);
    cyc(2);
    check_val("l3_wait_busy", 32'(busy3), 32'd1);
    rst = 1'b1;
    d_req = 1'b0;
    cyc(1);
    rst = 1'b0;
    check_val("l3_rst_busy", 32'(busy3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check_val("l3_rst_noack", {30'd0, d_ack3, busy3}, 32'd0);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc(4);
    check_val("l3_ack_early", 32'(d_ack3), 32'd0);
    cyc(1);
    check_val("l3_ack", 32'(d_ack3), 32'd1);
    check_val("l3_rdata", d_rdata3, 32'hC0DE_0040);
    drop_all();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the multi-cycle CPU's instruction-fetch path, its data-access path (lw/sw) and the program loader. It sits between the ControlUnit-driven datapath and the memory macro. It sequences each access through issue, wait and response phases and returns a one-cycle acknowledge to the winner, so the CPU FSM stalls in IF/MEM until the ack arrives.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4); m_rdata is valid MEM_LAT cycles after the m_en cycle

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction fetch request (read only), level
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  one-cycle misaligned-fetch pulse, replaces i_ack
- i_rdata  out  DATA_W  fetched word, valid while i_ack=1
- d_req, d_we  in  1 each  data request; d_we=1 write (sw), 0 read (lw)
- d_addr, d_wdata  in  ADDR_W, DATA_W  data address / store data
- d_ack, d_err  out  1 each  as i_ack / i_err for the data port
- d_rdata  out  DATA_W  load word, valid while d_ack=1
- l_req, l_we  in  1 each  loader request / write enable
- l_addr, l_wdata  in  ADDR_W, DATA_W  loader address / data; l_addr[1:0] ignored
- l_ack  out  1  loader completion pulse
- l_rdata  out  DATA_W  loader read word, valid while l_ack=1
- m_en, m_we  out  1 each  memory enable / write strobe
- m_addr  out  ADDR_W  always {addr[ADDR_W-1:2],2'b00}
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. Latched per transaction: owner (I/D/L), we, addr, wdata.
- IDLE: sample requests. Priority: L > round-robin(I, D). rr_last records the last I/D winner; on an I/D tie the other port wins. Nothing requested: stay in IDLE.
- Alignment check in IDLE: a winning I or D with addr[1:0]≠0 goes to RESP with err, not ack. No memory access; rr_last still updates.
- ISSUE: m_en=1 for exactly one cycle; m_we=we; m_addr, m_wdata from latched values.
  - Write: next state RESP.
  - Read: next state WAIT, lat_cnt loaded with MEM_LAT-1.
- WAIT: decrement lat_cnt. When lat_cnt=0, capture m_rdata into the owner's rdata register and go to RESP. For MEM_LAT=1, capture happens in the first WAIT cycle.
- RESP: assert exactly one of owner ack/err for one cycle, then IDLE. Requests are ignored in RESP.
  - A req still high in the following IDLE is a new transaction.
  - A requester wanting one access drops req in the cycle after its ack.
- Requesters hold req, addr, we and wdata stable from req assertion until ack/err. Changes mid-transaction have no effect (values latched in IDLE).
- No preemption: l_req arriving mid-transaction waits for IDLE.
- rdata registers hold their last captured value; they are meaningful only during their ack.

## Timing
- Reset values: state=IDLE, rr_last=D (first I/D tie goes to I), lat_cnt=0, all acks/errs=0, m_en=m_we=0, m_addr=m_wdata=0, all rdata=0, busy=0.
- rst mid-transaction: next cycle is IDLE with all reset values. The in-flight read is discarded and no ack is issued.
- Read latency, req sampled in IDLE at cycle 0: ISSUE at 1, ack at cycle MEM_LAT+2.
- Write latency: ISSUE at 1, ack at 2.
- Misaligned: err at cycle 1, no m_en.
- Back-to-back reads from one port occur every MEM_LAT+3 cycles. Writes occur every 3 cycles.
- m_en is never high in two consecutive cycles. Acks are mutually exclusive.

## Test plan
- Single fetch, MEM_LAT=1, i_addr=0x0000_0040, memory word 0x2001_0005 -> m_en at cycle 1 with m_addr=0x40, i_ack and i_rdata=0x2001_0005 at cycle 3, busy high cycles 1-3.
- Simultaneous i_req and d_req (read 0x100) held for two transactions after reset -> I served first, then D. The next tie also alternates (D, I order after a D win).
- Store d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF -> m_en=m_we=1 at cycle 1 with that data, d_ack at cycle 2. A subsequent read of 0x200 returns 0xDEAD_BEEF.
- l_req asserted one cycle after i_req won -> fetch completes uninterrupted, then loader served before a pending d_req. l_addr=0x0000_0013 drives m_addr=0x10.
- d_addr=0x0000_0102 read -> d_err pulse at cycle 1, d_ack never, m_en stays 0.
- MEM_LAT=3 read with rst asserted in WAIT -> next cycle IDLE, no ack ever; a following read acks at cycle 5 after its sample.
